// File: rtl/sauria_pkg.sv
// Shared types for the SRAM read streamer: FSM state encoding and stream length width.
package sauria_pkg;

  localparam int LEN_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } stream_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered occupancy count and a synchronous flush.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage is reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_rd_streamer.sv
// Strided SRAM read streamer: issues credit-limited reads and streams the words out
// through a small buffer with valid/ready handshake.
//   state | meaning
//   IDLE  | waiting for i_start
//   RUN   | issuing reads while buffer credit and issue count allow
//   DRAIN | all reads issued, waiting for the last word to be accepted
module sram_rd_streamer
  import sauria_pkg::*;
#(
  parameter int ADR_W      = 10,
  parameter int SRAM_W     = 128,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [ADR_W-1:0]  i_base_addr,
  input  logic [ADR_W-1:0]  i_stride,
  input  logic [LEN_W-1:0]  i_length,
  output logic [ADR_W-1:0]  o_sram_addr,
  output logic              o_sram_rden,
  input  logic [SRAM_W-1:0] i_sram_data,
  output logic [SRAM_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_busy,
  output logic              o_done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  stream_state_t    state;
  logic [ADR_W-1:0] addr;
  logic [ADR_W-1:0] stride_q;
  logic [LEN_W-1:0] issue_cnt;
  logic [LEN_W-1:0] accept_cnt;
  logic             inflight;

  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   occupancy;
  logic             credit_ok;
  logic             rden;
  logic             push;
  logic             pop;

  // A read in flight already owns a buffer slot, so it counts against the credit.
  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};
  assign credit_ok = occupancy < (CNT_W + 1)'(FIFO_DEPTH);
  assign rden      = (state == RUN) && (issue_cnt != '0) && credit_ok;

  assign o_sram_rden = rden;
  assign o_sram_addr = addr;
  assign o_busy      = (state != IDLE);
  assign o_valid     = ~fifo_empty;

  assign push = inflight & ~i_abort & ~fifo_full;
  assign pop  = o_valid & i_ready & ~i_abort;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state      <= IDLE;
      addr       <= '0;
      stride_q   <= '0;
      issue_cnt  <= '0;
      accept_cnt <= '0;
      inflight   <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (i_abort) begin
        state      <= IDLE;
        issue_cnt  <= '0;
        accept_cnt <= '0;
        inflight   <= 1'b0;
      end else begin
        inflight <= rden;
        if (pop && (accept_cnt != '0)) begin
          accept_cnt <= accept_cnt - LEN_W'(1);
        end
        case (state)
          IDLE: begin
            if (i_start) begin
              addr       <= i_base_addr;
              stride_q   <= i_stride;
              issue_cnt  <= i_length;
              accept_cnt <= i_length;
              state      <= (i_length == '0) ? DRAIN : RUN;
            end
          end
          RUN: begin
            if (rden) begin
              addr      <= addr + stride_q;
              issue_cnt <= issue_cnt - LEN_W'(1);
              if (issue_cnt == LEN_W'(1)) begin
                state <= DRAIN;
              end
            end
          end
          DRAIN: begin
            if (accept_cnt == '0) begin
              o_done <= 1'b1;
              state  <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  sync_fifo #(
    .WIDTH (SRAM_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rstn),
    .flush (i_abort),
    .push  (push),
    .pop   (pop),
    .wdata (i_sram_data),
    .rdata (o_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: doc/sram_rd_streamer.md
SRAM_RD_STREAMER -- requirements
Module: sram_rd_streamer

Interface
REQ-001 The block SHALL have parameter ADR_W, default 10, meaning the accelerator-side SRAM word address width.
REQ-002 The block SHALL have parameter SRAM_W, default 128, meaning the accelerator-side data width.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the output buffer depth in words (power of two, >=2).
REQ-004 The block SHALL have port i_clk, input, 1 bit, the single clock for all logic.
REQ-005 The block SHALL have port i_rstn, input, 1 bit, the reset: asynchronous, active-low.
REQ-006 The block SHALL have port i_start, input, 1 bit, a single-cycle pulse that launches a stream.
REQ-007 The block SHALL have port i_abort, input, 1 bit, which cancels the stream and flushes the buffer.
REQ-008 The block SHALL have port i_base_addr, input, ADR_W bits, the first word address.
REQ-009 The block SHALL have port i_stride, input, ADR_W bits, the address increment per word.
REQ-010 The block SHALL have port i_length, input, 16 bits, the number of words to read.
REQ-011 The block SHALL have port o_sram_addr, output, ADR_W bits, the read address to the SRAM wrapper.
REQ-012 The block SHALL have port o_sram_rden, output, 1 bit, the read enable to the SRAM wrapper.
REQ-013 The block SHALL have port i_sram_data, input, SRAM_W bits, the read data, valid the cycle after o_sram_rden.
REQ-014 The block SHALL have port o_data, output, SRAM_W bits, the downstream stream data.
REQ-015 The block SHALL have port o_valid, output, 1 bit, asserted when o_data holds a valid word.
REQ-016 The block SHALL have port i_ready, input, 1 bit, the downstream accept signal.
REQ-017 The block SHALL have port o_busy, output, 1 bit, high whenever the state is not IDLE.
REQ-018 The block SHALL have port o_done, output, 1 bit, a one-cycle pulse when the last word has been accepted.

Function
REQ-019 The block SHALL implement the states IDLE, RUN and DRAIN.
REQ-020 In IDLE, i_start SHALL latch base, stride and length, set the issue counter and the accept counter to length, and move to RUN; if length==0 it SHALL instead move to DRAIN.
REQ-021 i_start SHALL be ignored while o_busy is high.
REQ-022 In RUN, the block SHALL assert o_sram_rden when (fifo_count + inflight) < FIFO_DEPTH and the issue counter is nonzero; inflight is 1 if rden was asserted in the previous cycle.
REQ-023 On each read, the block SHALL drive o_sram_addr with the current address, then advance it by stride modulo 2^ADR_W (wrap-around silently), and decrement the issue counter.
REQ-024 The block SHALL move from RUN to DRAIN in the cycle after the final read is issued.
REQ-025 The block SHALL push i_sram_data into the FIFO in the cycle after each o_sram_rden; the credit rule guarantees the FIFO is never written while full.
REQ-026 o_valid SHALL equal FIFO-not-empty, o_data SHALL be the FIFO head, and a pop SHALL occur on o_valid & i_ready; a simultaneous push and pop SHALL keep the count unchanged.
REQ-027 The accept counter SHALL decrement on each pop; when it reaches 0 in DRAIN, o_done SHALL pulse for one cycle and the state SHALL return to IDLE.
REQ-028 A stream of length 0 SHALL pulse o_done in the cycle after entering DRAIN, with no reads issued.
REQ-029 Latency: with i_ready high, the first o_valid SHALL assert exactly 3 cycles after i_start is sampled, and throughput SHALL sustain 1 word per cycle.
REQ-030 o_valid and o_data SHALL remain stable while i_ready is low.
REQ-031 i_abort SHALL take priority over all other events: next cycle state=IDLE, FIFO empty, counters cleared, no o_done, and any read data still in flight discarded.

Reset
REQ-032 On i_rstn low, the block SHALL asynchronously set: state IDLE, o_sram_rden=0, o_sram_addr=0, o_valid=0, o_busy=0, o_done=0, FIFO pointers/count=0, inflight=0; o_data SHALL be 0.
REQ-033 Reset asserted mid-stream SHALL behave as i_abort, with no residual read or output after reset release.

Structure
REQ-034 The state enum and the length width constant (16) SHALL live in the shared package sauria_pkg.
REQ-035 The output buffer SHALL be one sub-module, sync_fifo (params WIDTH and DEPTH; push, pop, full, empty, count).
REQ-036 All other logic SHALL be in sram_rd_streamer; o_sram_rden SHALL be combinational from registered state and counters only, with no path from i_ready.

Verification
REQ-037 The bench SHALL cover: base=0x010, stride=1, length=8, ready=1 -> addrs 0x010..0x017 on consecutive cycles, first o_valid 3 cycles after start, 8 words in order, one o_done.
REQ-038 The bench SHALL cover: base=0x3FE, stride=1, length=4 (ADR_W=10) -> addrs 0x3FE, 0x3FF, 0x000, 0x001.
REQ-039 The bench SHALL cover: length=16 with ready low for 10 cycles -> at most FIFO_DEPTH words buffered, no overflow, o_data stable, all 16 delivered once ready rises.
REQ-040 The bench SHALL cover: length=0 -> no o_sram_rden, o_done pulses 2 cycles after start.
REQ-041 The bench SHALL cover: i_abort on the cycle a read returns, length=8 -> o_valid=0 and o_busy=0 next cycle, no o_done, and a new start afterwards streams cleanly.
REQ-042 The bench SHALL cover: i_start pulsed while busy -> ignored, and the original stream completes unchanged.
